// File: rtl/fetch_align_pkg.sv
// -----------------------------------------------------------------------------
// fetch_align_pkg
//   Shared definitions for the fetch alignment buffer and decode.
//   - Instruction length encoding on the two MSBs of a left-aligned
//     instruction:
//       LEN16 = 2'b0x  (1 halfword)
//       LEN32 = 2'b10  (2 halfwords)
//       LEN64 = 2'b11  (4 halfwords)
//   - HW_PER_WORD : halfwords per 64-bit memory word.
//   - hw_needed() : halfwords needed by an instruction given its top 2 bits.
// -----------------------------------------------------------------------------
package fetch_align_pkg;

    localparam int HW_PER_WORD = 4;

    // LEN16 is 2'b0x: only the MSB identifies it.
    localparam logic       LEN16_MSB = 1'b0;
    localparam logic [1:0] LEN32     = 2'b10;
    localparam logic [1:0] LEN64     = 2'b11;

    function automatic logic [2:0] hw_needed(input logic [1:0] len_bits);
        logic [2:0] n;
        if (len_bits[1] == LEN16_MSB) begin
            n = 3'd1;
        end else if (len_bits == LEN32) begin
            n = 3'd2;
        end else begin
            n = 3'd4;
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// -----------------------------------------------------------------------------
// fetch_len_decode
//   Combinational instruction length decode: maps the two MSBs of a
//   left-aligned instruction to the number of halfwords it occupies.
//   Ports:
//     len_bits in  2  inst[63:62]
//     needed   out 3  halfwords required (1, 2 or 4)
// -----------------------------------------------------------------------------
module fetch_len_decode
    import fetch_align_pkg::*;
(
    input  logic [1:0] len_bits,
    output logic [2:0] needed
);

    assign needed = hw_needed(len_bits);

endmodule

// File: rtl/fetch_align.sv
// -----------------------------------------------------------------------------
// fetch_align
//   Fetch alignment buffer directly upstream of instruction decode. Issues
//   64-bit aligned reads, queues returned words in a halfword-granular shift
//   buffer and presents the next instruction left-aligned on inst_out.
//
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     redirect, redirect_pc flush buffer and restart fetch at redirect_pc
//     mem_req_valid/ready   read request handshake
//     mem_req_addr          8-byte aligned request address
//     mem_rsp_valid/data    in-order read data, always accepted
//     inst_out              head instruction, left-aligned, zero past fill
//     inst_valid            head instruction fully present
//     inst_pc               address of the head instruction
//     advance16/32/64       retire 1/2/4 halfwords from the head
//
//   Optional build macro FETCH_ALIGN_PERF_EN adds:
//     starve_cycles  out 32  cycles with inst_valid=0 and no redirect
//     redirect_count out 32  redirect cycles
//   both saturating.
// -----------------------------------------------------------------------------
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter int          BUF_WORDS = 3,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data,
    output logic [63:0] inst_out,
    output logic        inst_valid,
    output logic [63:0] inst_pc,
    input  logic        advance16,
    input  logic        advance32,
    input  logic        advance64
`ifdef FETCH_ALIGN_PERF_EN
    ,
    output logic [31:0] starve_cycles,
    output logic [31:0] redirect_count
`endif
);

    localparam int CAP = HW_PER_WORD * BUF_WORDS;  // capacity in halfwords
    localparam int BW  = 16 * CAP;                 // buffer width in bits
    localparam int FW  = $clog2(CAP + 1);          // fill counter width
    localparam int OW  = $clog2(BUF_WORDS + 1);    // outstanding counter width
    localparam int SW  = FW + 3;                   // room for fill + 4*outst + 4

    // Buffer: halfword 0 (the head) sits in the MSBs so the head instruction
    // is always buf_q[BW-1 -: 64] and retiring is a plain left shift.
    logic [BW-1:0] buf_q, buf_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] discard_q, discard_d;
    logic [1:0]    skip_q, skip_d;
    logic [63:0]   fetch_addr_q, fetch_addr_d;
    logic [63:0]   pc_q, pc_d;

    logic [2:0]    needed;
    logic [2:0]    adv_hw;
    logic [2:0]    kept_hw;
    logic          req_fire;
    logic          keep;
    logic [FW-1:0] base;
    logic [OW-1:0] rsp_dec;
    logic [63:0]   aligned;
    logic [BW-1:0] shifted;
    logic [BW-1:0] keep_mask;
    logic [BW-1:0] ins;

    // Only the halfword-select bits of redirect_pc matter; bit 0 is dropped.
    logic unused_pc_bit;
    assign unused_pc_bit = redirect_pc[0];

    // ------------------------------------------------------------------
    // Head view and length decode
    // ------------------------------------------------------------------
    // Halfwords at or beyond fill read as zero, so stale buffer contents
    // never leak onto inst_out.
    assign inst_out = buf_q[BW-1 -: 64] & ~(64'hFFFF_FFFF_FFFF_FFFF >> {fill_q, 4'b0000});

    fetch_len_decode u_len (
        .len_bits (inst_out[63:62]),
        .needed   (needed)
    );

    assign inst_valid = (fill_q != '0) && (SW'(fill_q) >= SW'(needed));
    assign inst_pc    = pc_q;

    // ------------------------------------------------------------------
    // Request side: only issue when the word is guaranteed to fit, counting
    // both buffered halfwords and words still in flight.
    // ------------------------------------------------------------------
    assign mem_req_valid = rst_n && !redirect &&
                           ((SW'(fill_q) + SW'({outst_q, 2'b00}) + SW'(HW_PER_WORD)) <= SW'(CAP));
    assign mem_req_addr  = fetch_addr_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        adv_hw = 3'd0;
        if (inst_valid && !redirect) begin
            if (advance64) begin
                adv_hw = 3'd4;
            end else if (advance32) begin
                adv_hw = 3'd2;
            end else if (advance16) begin
                adv_hw = 3'd1;
            end
        end
    end

    assign keep    = mem_rsp_valid && (discard_q == '0) && !redirect;
    assign kept_hw = 3'd4 - {1'b0, skip_q};
    assign base    = fill_q - FW'(adv_hw);
    assign rsp_dec = OW'(mem_rsp_valid);

    // Drop the leading skip halfwords of the returned word, then land the
    // rest directly behind what survives this cycle's advance.
    assign aligned   = mem_rsp_data << {skip_q, 4'b0000};
    assign shifted   = buf_q << {adv_hw, 4'b0000};
    assign keep_mask = ~({BW{1'b1}} >> {base, 4'b0000});
    assign ins       = (BW'(aligned) << (BW - 64)) >> {base, 4'b0000};

    always_comb begin
        buf_d        = buf_q;
        fill_d       = fill_q;
        outst_d      = outst_q;
        discard_d    = discard_q;
        skip_d       = skip_q;
        fetch_addr_d = fetch_addr_q;
        pc_d         = pc_q;

        if (redirect) begin
            // Everything currently in flight is stale; the response landing
            // this very cycle is already accounted for by dropping it here.
            fill_d       = '0;
            outst_d      = outst_q - rsp_dec;
            discard_d    = outst_q - rsp_dec;
            skip_d       = redirect_pc[2:1];
            fetch_addr_d = {redirect_pc[63:3], 3'b000};
            pc_d         = {redirect_pc[63:1], 1'b0};
        end else begin
            buf_d   = (shifted & keep_mask) | (keep ? ins : '0);
            fill_d  = base + (keep ? FW'(kept_hw) : '0);
            outst_d = outst_q + OW'(req_fire) - rsp_dec;
            pc_d    = pc_q + {60'b0, adv_hw, 1'b0};
            if (mem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (keep) begin
                skip_d = 2'b00;
            end
            if (req_fire) begin
                fetch_addr_d = fetch_addr_q + 64'd8;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q        <= '0;
            fill_q       <= '0;
            outst_q      <= '0;
            discard_q    <= '0;
            skip_q       <= 2'b00;
            fetch_addr_q <= {RESET_PC[63:3], 3'b000};
            pc_q         <= RESET_PC;
        end else begin
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            skip_q       <= skip_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
        end
    end

`ifdef FETCH_ALIGN_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cycles  <= '0;
            redirect_count <= '0;
        end else begin
            if (!inst_valid && !redirect && (starve_cycles != 32'hFFFF_FFFF)) begin
                starve_cycles <= starve_cycles + 32'd1;
            end
            if (redirect && (redirect_count != 32'hFFFF_FFFF)) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_align.sv
module tb_fetch_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data  = 64'h0;
    logic [63:0] inst_out;
    logic        inst_valid;
    logic [63:0] inst_pc;
    logic        advance16, advance32, advance64;
`ifdef FETCH_ALIGN_PERF_EN
    logic [31:0] starve_cycles;
    logic [31:0] redirect_count;
`endif

    always #5 clk = ~clk;

    fetch_align #(.BUF_WORDS(3), .RESET_PC(64'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_out      (inst_out),
        .inst_valid    (inst_valid),
        .inst_pc       (inst_pc),
        .advance16     (advance16),
        .advance32     (advance32),
        .advance64     (advance64)
`ifdef FETCH_ALIGN_PERF_EN
        ,
        .starve_cycles  (starve_cycles),
        .redirect_count (redirect_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- memory model ----------------
    logic [63:0] mem [logic [63:0]];
    logic [63:0] pend_q [$];
    int fires     = 0;
    int rsp_count = 0;
    int rsp_limit = 0;

    // Unwritten addresses return halfwords equal to their own address[11:0]
    // (all 16-bit instructions).
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        if (mem.exists(a)) return mem[a];
        for (int i = 0; i < 4; i++) w[63-16*i -: 16] = {4'h0, a[11:0] + 12'(2*i)};
        return w;
    endfunction

    always begin
        @(posedge clk);
        if (!rst_n) pend_q.delete();
        else if (mem_req_valid && mem_req_ready) begin
            pend_q.push_back(mem_req_addr);
            fires++;
        end
        @(negedge clk);
        if (rst_n && rsp_count < rsp_limit && pend_q.size() > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend_q.pop_front());
            rsp_count++;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 64'h0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] pc;
        logic [63:0] bits;
        int          len;   // 1/2/4 halfwords compared, 0 = whole inst_out
        logic        valid;
    } exp_t;
    exp_t exp_q [$];

    typedef struct {
        logic [63:0] pc;
        logic [63:0] out;
        logic [63:0] pc_exp;
        logic        valid;
    } vec_t;
    vec_t vecs [8];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic [63:0] bits, input int len, input logic v);
        exp_t e;
        e.pc = pc; e.bits = bits; e.len = len; e.valid = v;
        exp_q.push_back(e);
    endtask

    task automatic check_head(input string name);
        exp_t e;
        logic [63:0] m;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        m = (e.len == 1) ? 64'hFFFF_0000_0000_0000 :
            (e.len == 2) ? 64'hFFFF_FFFF_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
        chk({name, " inst_out"}, inst_out & m, e.bits);
        chk({name, " inst_pc"}, inst_pc, e.pc);
        chk({name, " inst_valid"}, {63'b0, inst_valid}, {63'b0, e.valid});
    endtask

    // Decode stand-in: wait for each expected instruction, check it, retire it.
    task automatic consume(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            int t;
            int len;
            exp_t e;
            t = 0;
            while (!inst_valid && t < 60) begin cycle(); t++; end
            if (!inst_valid) begin
                checks++; failures++;
                $display("FAIL %s: timeout waiting for inst_valid (item %0d)", name, k);
                if (exp_q.size() > 0) e = exp_q.pop_front();
            end else begin
                len = (exp_q.size() > 0) ? exp_q[0].len : 1;
                check_head(name);
                advance16 = (len == 1);
                advance32 = (len == 2);
                advance64 = (len == 4);
                cycle();
                advance16 = 0; advance32 = 0; advance64 = 0;
            end
        end
    endtask

    task automatic redir(input logic [63:0] pc);
        redirect_pc = pc;
        redirect    = 1'b1;
        cycle();
        redirect    = 1'b0;
    endtask

    task automatic quiesce();
        mem_req_ready = 1'b0;
        rsp_limit     = rsp_count + 1000;
        repeat (8) cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fb;
        logic [63:0] p;

        vecs[0] = '{64'h500, 64'h8123_4567_C89A_0BCD, 64'h500, 1'b1};
        vecs[1] = '{64'h502, 64'h4567_C89A_0BCD_0000, 64'h502, 1'b1};
        vecs[2] = '{64'h503, 64'h4567_C89A_0BCD_0000, 64'h502, 1'b1};
        vecs[3] = '{64'h504, 64'hC89A_0BCD_0000_0000, 64'h504, 1'b0};
        vecs[4] = '{64'h506, 64'h0BCD_0000_0000_0000, 64'h506, 1'b1};
        vecs[5] = '{64'h508, 64'hC000_0000_0000_0001, 64'h508, 1'b1};
        vecs[6] = '{64'h50C, 64'h0000_0001_0000_0000, 64'h50C, 1'b1};
        vecs[7] = '{64'h50E, 64'h0001_0000_0000_0000, 64'h50E, 1'b1};

        mem[64'h0]   = 64'h1111_8222_2222_C333;
        mem[64'h8]   = 64'h3333_3333_4444_4444;
        mem[64'h100] = 64'h0001_0002_0003_0004;
        mem[64'h108] = 64'h0005_0006_0007_0008;
        mem[64'h200] = 64'h0001_0002_0003_8004;
        mem[64'h208] = 64'h0005_0006_0007_0008;
        mem[64'h300] = 64'hC000_1111_2222_3333;
        mem[64'h308] = 64'h0AAA_0BBB_0CCC_0DDD;
        mem[64'h500] = 64'h8123_4567_C89A_0BCD;
        mem[64'h508] = 64'hC000_0000_0000_0001;

        rst_n = 0; redirect = 0; redirect_pc = 0; mem_req_ready = 1;
        advance16 = 0; advance32 = 0; advance64 = 0;
        rsp_limit = 1000;
        repeat (3) cycle();
        chk("reset mem_req_valid", {63'b0, mem_req_valid}, 64'h0);
        chk("reset inst_valid", {63'b0, inst_valid}, 64'h0);
        chk("reset inst_out", inst_out, 64'h0);
        chk("reset inst_pc", inst_pc, 64'h0);
        rst_n = 1;

        // Mixed-length stream from reset.
        push_exp(64'h0,  64'h1111 << 48, 1, 1'b1);
        push_exp(64'h2,  64'h8222_2222 << 32, 2, 1'b1);
        push_exp(64'h6,  64'hC333_3333_3333_4444, 4, 1'b1);
        push_exp(64'hE,  64'h4444 << 48, 1, 1'b1);
        push_exp(64'h10, 64'h0010 << 48, 1, 1'b1);
        push_exp(64'h12, 64'h0012 << 48, 1, 1'b1);
        consume(6, "stream");

        // 32-bit head with one halfword present; advance32 must be ignored.
        quiesce();
        redir(64'h206);
        rsp_limit = rsp_count + 1;
        mem_req_ready = 1;
        repeat (6) cycle();
        push_exp(64'h206, 64'h8004_0000_0000_0000, 0, 1'b0);
        check_head("partial");
        advance32 = 1;
        cycle();
        advance32 = 0;
        push_exp(64'h206, 64'h8004_0000_0000_0000, 0, 1'b0);
        check_head("partial ignored adv");
        rsp_limit = rsp_count + 1000;
        push_exp(64'h206, 64'h8004_0005 << 32, 2, 1'b1);
        push_exp(64'h20A, 64'h0006 << 48, 1, 1'b1);
        consume(2, "partial resume");

        // Redirect with 2 reads outstanding: both must be discarded.
        quiesce();
        redir(64'h600);
        rsp_limit = rsp_count;
        fb = fires;
        mem_req_ready = 1;
        repeat (2) cycle();
        mem_req_ready = 0;
        chk("outstanding setup", 64'(fires - fb), 64'd2);
        redir(64'h106);
        mem_req_ready = 1;
        rsp_limit = rsp_count + 1000;
        push_exp(64'h106, 64'h0004 << 48, 1, 1'b1);
        push_exp(64'h108, 64'h0005 << 48, 1, 1'b1);
        push_exp(64'h10A, 64'h0006 << 48, 1, 1'b1);
        consume(3, "discard");

        // Response and advance64 in the same cycle with fill=4.
        quiesce();
        redir(64'h300);
        rsp_limit = rsp_count + 1;
        mem_req_ready = 1;
        repeat (6) cycle();
        push_exp(64'h300, 64'hC000_1111_2222_3333, 0, 1'b1);
        check_head("merge head");
        rsp_limit = rsp_count + 1;
        advance64 = 1;
        cycle();
        advance64 = 0;
        push_exp(64'h308, 64'h0AAA_0BBB_0CCC_0DDD, 0, 1'b1);
        check_head("merge same cycle");
        cycle();
        push_exp(64'h308, 64'h0AAA_0BBB_0CCC_0DDD, 0, 1'b1);
        check_head("merge hold");

        // Decode stalled, memory always ready: exactly 3 words fit.
        quiesce();
        redir(64'h400);
        fb = fires;
        rsp_limit = rsp_count + 1000;
        mem_req_ready = 1;
        repeat (12) cycle();
        chk("full fires", 64'(fires - fb), 64'd3);
        chk("full mem_req_valid", {63'b0, mem_req_valid}, 64'h0);
        mem_req_ready = 0;
        for (int k = 0; k < 12; k++) begin
            p = 64'h400 + 64'(2*k);
            push_exp(p, {4'h0, p[11:0], 48'h0}, 1, 1'b1);
        end
        consume(12, "full drain");
        repeat (3) cycle();
        chk("full drained inst_valid", {63'b0, inst_valid}, 64'h0);

        // Alignment table: one word after a redirect to each halfword offset.
        foreach (vecs[i]) begin
            quiesce();
            redir(vecs[i].pc);
            rsp_limit = rsp_count + 1;
            mem_req_ready = 1;
            repeat (4) cycle();
            mem_req_ready = 0;
            push_exp(vecs[i].pc_exp, vecs[i].out, 0, vecs[i].valid);
            check_head($sformatf("align vec%0d", i));
        end

        // Address wrap-around.
        quiesce();
        redir(64'hFFFF_FFFF_FFFF_FFFC);
        rsp_limit = rsp_count + 1000;
        mem_req_ready = 1;
        push_exp(64'hFFFF_FFFF_FFFF_FFFC, 64'h0FFC << 48, 1, 1'b1);
        push_exp(64'hFFFF_FFFF_FFFF_FFFE, 64'h0FFE << 48, 1, 1'b1);
        push_exp(64'h0, 64'h1111 << 48, 1, 1'b1);
        consume(3, "wrap");

        // Mid-operation reset, then starvation and redirect counting.
        repeat (3) cycle();
        rst_n = 0;
        mem_req_ready = 0;
        repeat (2) cycle();
        chk("midreset inst_valid", {63'b0, inst_valid}, 64'h0);
        chk("midreset inst_out", inst_out, 64'h0);
        chk("midreset inst_pc", inst_pc, 64'h0);
        chk("midreset mem_req_valid", {63'b0, mem_req_valid}, 64'h0);
        rst_n = 1;
        repeat (5) cycle();
        redir(64'h0);
`ifdef FETCH_ALIGN_PERF_EN
        chk("perf starve_cycles", {32'b0, starve_cycles}, 64'd5);
        chk("perf redirect_count", {32'b0, redirect_count}, 64'd1);
`endif
        mem_req_ready = 1;
        rsp_limit = rsp_count + 1000;
        push_exp(64'h0, 64'h1111 << 48, 1, 1'b1);
        push_exp(64'h2, 64'h8222_2222 << 32, 2, 1'b1);
        consume(2, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
